// File: rtl/q0_inverse_engine.sv
// -----------------------------------------------------------------------------
// q0_inverse_engine
//
// Builds and serves the inverse of the Twofish q0 byte permutation.
// When it leaves reset (INIT_ON_RESET=1), or when start is requested, the
// engine sweeps every byte x through the forward q0 block. It writes
// mem[q0(x)] = x into a 256x8 register table. The sweep takes 256 cycles.
// After that, the engine answers lookups y -> q0^-1(y) through a
// valid/ready stream. The result appears one cycle after the request is
// accepted. The stream can accept one request per cycle.
//
// Parameters
//   INIT_ON_RESET  1: build the table straight out of reset
//                  0: wait in IDLE until start is seen
//
// Optional feature macro: Q0_INV_SELFCHECK_EN
//   When this macro is defined, a seen vector tracks which table slots each
//   build writes. err goes high if a slot is written twice. err also goes
//   high if any slot is still unwritten when the build ends. When the macro
//   is undefined, err is tied low.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   start        level request to (re)build the table
//   busy         high while the table is being built
//   table_ready  table valid, lookups may be accepted
//   in_valid     lookup request valid
//   in_ready     lookup request accepted when in_valid && in_ready
//   in_data      byte y to invert
//   out_valid    result valid
//   out_ready    consumer takes result when out_valid && out_ready
//   out_data     x such that q0(x) == y
//   err          sticky table-consistency error
// -----------------------------------------------------------------------------

// Combinational forward Twofish q0 permutation.
// The permutation is built from nibble mixing and four 4-bit substitution tables.
//   x      input byte
//   y      q0(x)
module q0_fwd (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  function automatic logic [3:0] t0_lut(input logic [3:0] i);
    logic [3:0] r;
    case (i)
      4'h0: r = 4'h8;  4'h1: r = 4'h1;  4'h2: r = 4'h7;  4'h3: r = 4'hD;
      4'h4: r = 4'h6;  4'h5: r = 4'hF;  4'h6: r = 4'h3;  4'h7: r = 4'h2;
      4'h8: r = 4'h0;  4'h9: r = 4'hB;  4'hA: r = 4'h5;  4'hB: r = 4'h9;
      4'hC: r = 4'hE;  4'hD: r = 4'hC;  4'hE: r = 4'hA;  4'hF: r = 4'h4;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] t1_lut(input logic [3:0] i);
    logic [3:0] r;
    case (i)
      4'h0: r = 4'hE;  4'h1: r = 4'hC;  4'h2: r = 4'hB;  4'h3: r = 4'h8;
      4'h4: r = 4'h1;  4'h5: r = 4'h2;  4'h6: r = 4'h3;  4'h7: r = 4'h5;
      4'h8: r = 4'hF;  4'h9: r = 4'h4;  4'hA: r = 4'hA;  4'hB: r = 4'h6;
      4'hC: r = 4'h7;  4'hD: r = 4'h0;  4'hE: r = 4'h9;  4'hF: r = 4'hD;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] t2_lut(input logic [3:0] i);
    logic [3:0] r;
    case (i)
      4'h0: r = 4'hB;  4'h1: r = 4'hA;  4'h2: r = 4'h5;  4'h3: r = 4'hE;
      4'h4: r = 4'h6;  4'h5: r = 4'hD;  4'h6: r = 4'h9;  4'h7: r = 4'h0;
      4'h8: r = 4'hC;  4'h9: r = 4'h8;  4'hA: r = 4'hF;  4'hB: r = 4'h3;
      4'hC: r = 4'h2;  4'hD: r = 4'h4;  4'hE: r = 4'h7;  4'hF: r = 4'h1;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] t3_lut(input logic [3:0] i);
    logic [3:0] r;
    case (i)
      4'h0: r = 4'hD;  4'h1: r = 4'h7;  4'h2: r = 4'hF;  4'h3: r = 4'h4;
      4'h4: r = 4'h1;  4'h5: r = 4'h2;  4'h6: r = 4'h6;  4'h7: r = 4'hE;
      4'h8: r = 4'h9;  4'h9: r = 4'hB;  4'hA: r = 4'h3;  4'hB: r = 4'h0;
      4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'hC;  4'hF: r = 4'hA;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  logic [3:0] a0_s, b0_s, a1_s, b1_s, a2_s, b2_s, a3_s, b3_s, a4_s, b4_s;

  // Two rounds of nibble mixing and substitution. {a[0],3'b000} is the 4-bit (8*a mod 16) term.
  always_comb begin
    a0_s = x[7:4];
    b0_s = x[3:0];
    a1_s = a0_s ^ b0_s;
    b1_s = a0_s ^ ror4(b0_s) ^ {a0_s[0], 3'b000};
    a2_s = t0_lut(a1_s);
    b2_s = t1_lut(b1_s);
    a3_s = a2_s ^ b2_s;
    b3_s = a2_s ^ ror4(b2_s) ^ {a2_s[0], 3'b000};
    a4_s = t2_lut(a3_s);
    b4_s = t3_lut(b3_s);
    y    = {b4_s, a4_s};
  end

endmodule

module q0_inverse_engine #(
  parameter logic INIT_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       table_ready,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? ST_BUILD : ST_IDLE;

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [7:0] mem_r [0:255];
  logic [7:0] q0_val_s;
  logic       rebuild_s;
  logic       build_entry_s;
  logic       accept_s;
  logic       pop_s;

  q0_fwd u_q0_fwd (
    .x (cnt_r),
    .y (q0_val_s)
  );

  // A rebuild from READY is allowed only with no pending result. That
  // request also blocks a lookup in the same cycle. Without this gate, the
  // lookup would read a table that is about to be rewritten.
  always_comb begin
    rebuild_s     = (state_r == ST_READY) && start && !out_valid;
    build_entry_s = ((state_r == ST_IDLE) && start) || rebuild_s;
    in_ready      = table_ready && (!out_valid || out_ready) && !rebuild_s;
    accept_s      = in_valid && in_ready;
    pop_s         = out_valid && out_ready;
  end

  // Table fill: one inverse entry per BUILD cycle. The table has no reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_BUILD) begin
      mem_r[q0_val_s] <= cnt_r;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RESET_STATE;
      busy        <= INIT_ON_RESET;
      table_ready <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      cnt_r       <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_BUILD;
            busy    <= 1'b1;
            cnt_r   <= 8'h00;
          end
        end
        ST_BUILD: begin
          // The counter wraps to 0 on the final write, so it is clean for the next build.
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == 8'hFF) begin
            state_r     <= ST_READY;
            busy        <= 1'b0;
            table_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (rebuild_s) begin
            state_r     <= ST_BUILD;
            busy        <= 1'b1;
            table_ready <= 1'b0;
            cnt_r       <= 8'h00;
          end
          // An accept takes priority over a pop. This lets a simultaneous pop and accept keep out_valid high.
          if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= mem_r[in_data];
          end else if (pop_s) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy        <= 1'b0;
          table_ready <= 1'b0;
          out_valid   <= 1'b0;
          cnt_r       <= 8'h00;
        end
      endcase
    end
  end

`ifdef Q0_INV_SELFCHECK_EN
  logic [255:0] seen_r;
  logic [255:0] seen_next_s;

  // Mark the slot written this BUILD cycle.
  always_comb begin
    seen_next_s = seen_r | (256'd1 << q0_val_s);
  end

  // Duplicate-write and coverage check across one build. err is sticky until the next build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_r <= {256{1'b0}};
      err    <= 1'b0;
    end else if (build_entry_s) begin
      seen_r <= {256{1'b0}};
      err    <= 1'b0;
    end else if (state_r == ST_BUILD) begin
      seen_r <= seen_next_s;
      if (seen_r[q0_val_s]) begin
        err <= 1'b1;
      end
      if ((cnt_r == 8'hFF) && !(&seen_next_s)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_q0_inverse_engine.sv
module tb_q0_inverse_engine;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: INIT_ON_RESET = 1
  logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       busy, table_ready, in_ready, out_valid, err;
  logic [7:0] out_data;

  // Instance B: INIT_ON_RESET = 0
  logic       rst_b = 1'b1, start_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [7:0] in_data_b = 8'h00;
  logic       busy_b, table_ready_b, in_ready_b, out_valid_b, err_b;
  logic [7:0] out_data_b;

  q0_inverse_engine #(.INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .table_ready(table_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );

  q0_inverse_engine #(.INIT_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .table_ready(table_ready_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference forward q0, straight from the Twofish definition
  localparam logic [3:0] T0 [16] = '{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4};
  localparam logic [3:0] T1 [16] = '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD};
  localparam logic [3:0] T2 [16] = '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1};
  localparam logic [3:0] T3 [16] = '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA};

  function automatic logic [7:0] q0_model(input logic [7:0] x);
    logic [3:0] a, b, p, q;
    a = x[7:4];
    b = x[3:0];
    p = a ^ b;
    q = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
    a = T0[p];
    b = T1[q];
    p = a ^ b;
    q = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
    return {T3[q], T2[p]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lookup(input logic [7:0] y, input logic [7:0] x_exp);
    in_data  = y;
    in_valid = 1'b1;
    #1;
    check_eq("lookup_in_ready", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("lookup_valid", 16'(out_valid), 16'd1);
    check_eq("lookup_data", 16'(out_data), 16'(x_exp));
    tick();
    check_eq("lookup_popped", 16'(out_valid), 16'd0);
  endtask

  // Watchdog: the run must end by itself
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // 1. Reset values, then build length
    tick(); tick();
    check_eq("rst_busy", 16'(busy), 16'd1);
    check_eq("rst_table_ready", 16'(table_ready), 16'd0);
    check_eq("rst_in_ready", 16'(in_ready), 16'd0);
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_out_data", 16'(out_data), 16'h00);
    check_eq("rst_err", 16'(err), 16'd0);
    check_eq("rst_b_busy", 16'(busy_b), 16'd0);
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check_eq("build_len", 16'(n), 16'd256);
    check_eq("ready_after_build", 16'(table_ready), 16'd1);
    check_eq("in_ready_after_build", 16'(in_ready), 16'd1);
    check_eq("err_after_build", 16'(err), 16'd0);

    // 2. Directed lookups
    lookup(8'hA9, 8'h00);
    lookup(8'h67, 8'h01);
    lookup(8'h00, 8'hF7);
    lookup(8'hE0, 8'hFF);

    // 3. Backpressure, then pop and accept on the same edge
    out_ready = 1'b0;
    in_data   = 8'h04;
    in_valid  = 1'b1;
    tick();
    in_data = 8'h67;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 16'(out_valid), 16'd1);
      check_eq("bp_data", 16'(out_data), 16'h04);
      check_eq("bp_in_ready", 16'(in_ready), 16'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 16'(in_ready), 16'd1);
    tick();
    check_eq("pop_accept_valid", 16'(out_valid), 16'd1);
    check_eq("pop_accept_data", 16'(out_data), 16'h01);
    in_valid = 1'b0;
    tick();
    check_eq("pop_accept_drain", 16'(out_valid), 16'd0);

    // 4. Full back-to-back stream
    for (int y = 0; y < 256; y++) begin
      in_data  = 8'(y);
      in_valid = 1'b1;
      #1;
      check_eq("stream_in_ready", 16'(in_ready), 16'd1);
      tick();
      check_eq("stream_valid", 16'(out_valid), 16'd1);
      check_eq("stream_q0", 16'(q0_model(out_data)), 16'(y));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drain", 16'(out_valid), 16'd0);

    // 5. Rebuild, then reset at cnt=100
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA9;
    #1;
    check_eq("rebuild_blocks_in_ready", 16'(in_ready), 16'd0);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq("rebuild_busy", 16'(busy), 16'd1);
    check_eq("rebuild_table_ready", 16'(table_ready), 16'd0);
    check_eq("rebuild_no_accept", 16'(out_valid), 16'd0);
    repeat (100) tick();
    check_eq("mid_build_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    check_eq("rst2_busy", 16'(busy), 16'd1);
    check_eq("rst2_table_ready", 16'(table_ready), 16'd0);
    check_eq("rst2_out_data", 16'(out_data), 16'h00);
    check_eq("rst2_out_valid", 16'(out_valid), 16'd0);
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check_eq("rebuild_len", 16'(n), 16'd256);
    lookup(8'h04, 8'h04);

    // 6. INIT_ON_RESET = 0
    rst_b = 1'b0;
    in_valid_b = 1'b1;
    in_data_b  = 8'hA9;
    repeat (3) begin
      tick();
      check_eq("idle_in_ready", 16'(in_ready_b), 16'd0);
      check_eq("idle_busy", 16'(busy_b), 16'd0);
      check_eq("idle_out_valid", 16'(out_valid_b), 16'd0);
    end
    in_valid_b = 1'b0;
    start_b    = 1'b1;
    tick();
    start_b = 1'b0;
    check_eq("idle_start_busy", 16'(busy_b), 16'd1);
    n = 0;
    while (busy_b && n < 400) begin
      tick();
      n++;
    end
    check_eq("b_build_len", 16'(n), 16'd256);
    check_eq("b_table_ready", 16'(table_ready_b), 16'd1);
    check_eq("b_err", 16'(err_b), 16'd0);
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    check_eq("b_lookup_valid", 16'(out_valid_b), 16'd1);
    check_eq("b_lookup_data", 16'(out_data_b), 16'h00);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check_eq("start_ignored_busy", 16'(busy_b), 16'd0);
    check_eq("start_ignored_ready", 16'(table_ready_b), 16'd1);
    check_eq("start_ignored_valid", 16'(out_valid_b), 16'd1);
    check_eq("start_ignored_data", 16'(out_data_b), 16'h00);
    out_ready_b = 1'b1;
    tick();
    check_eq("b_pop", 16'(out_valid_b), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
